// File: rtl/apb_axi_bridge_pkg.sv
// rtl/apb_axi_bridge_pkg.sv - shared FSM encoding and AXI response codes for the APB to AXI4-Lite bridge
package apb_axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Both SLVERR and DECERR surface on APB as pslverr
    function automatic logic resp_is_error(input logic [1:0] resp);
        logic err;
        case (resp)
            RESP_OKAY, RESP_EXOKAY:   err = 1'b0;
            RESP_SLVERR, RESP_DECERR: err = 1'b1;
            default:                  err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/apb_axi_lite_bridge.sv
// rtl/apb_axi_lite_bridge.sv - APB3 completer issuing one AXI4-Lite master transaction per transfer
module apb_axi_lite_bridge
    import apb_axi_bridge_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WINDOW_SIZE = 1024
) (
    input  logic                  s_axi_clk,
    input  logic                  s_axi_aresetn,
    input  logic                  s_apb_psel,
    input  logic                  s_apb_penable,
    input  logic                  s_apb_pwrite,
    input  logic [ADDR_WIDTH-1:0] s_apb_paddr,
    input  logic [DATA_WIDTH-1:0] s_apb_pwdata,
    output logic                  s_apb_pready,
    output logic [DATA_WIDTH-1:0] s_apb_prdata,
    output logic                  s_apb_pslverr,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    // Offset is taken one bit wider so an address below BASE_ADDR lands far above the window
    localparam logic [ADDR_WIDTH:0] WIN_BASE = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] WIN_SIZE = (ADDR_WIDTH + 1)'(WINDOW_SIZE);

    state_t                state;
    logic [ADDR_WIDTH:0]   addr_off;
    logic                  in_window;
    logic                  aw_done;
    logic                  w_done;

    assign addr_off  = {1'b0, s_apb_paddr} - WIN_BASE;
    assign in_window = (addr_off < WIN_SIZE);
    assign aw_done   = !m_axi_awvalid || m_axi_awready;
    assign w_done    = !m_axi_wvalid  || m_axi_wready;

    always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state         <= ST_IDLE;
            s_apb_pready  <= 1'b0;
            s_apb_pslverr <= 1'b0;
            s_apb_prdata  <= '0;
            m_axi_awaddr  <= '0;
            m_axi_araddr  <= '0;
            m_axi_wdata   <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_apb_psel && !s_apb_penable) begin
                        m_axi_awaddr <= s_apb_paddr;
                        m_axi_araddr <= s_apb_paddr;
                        m_axi_wdata  <= s_apb_pwdata;
                        if (!in_window) begin
                            s_apb_pready  <= 1'b1;
                            s_apb_pslverr <= 1'b1;
                            s_apb_prdata  <= '0;
                            state         <= ST_DONE;
                        end else if (s_apb_pwrite) begin
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= ST_WR_REQ;
                        end else begin
                            m_axi_arvalid <= 1'b1;
                            state         <= ST_RD_REQ;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
                    if (aw_done && w_done) begin
                        m_axi_bready <= 1'b1;
                        state        <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready  <= 1'b0;
                        s_apb_pready  <= 1'b1;
                        s_apb_pslverr <= resp_is_error(m_axi_bresp);
                        s_apb_prdata  <= '0;
                        state         <= ST_DONE;
                    end
                end
                ST_RD_REQ: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready  <= 1'b0;
                        s_apb_pready  <= 1'b1;
                        s_apb_pslverr <= resp_is_error(m_axi_rresp);
                        s_apb_prdata  <= m_axi_rdata;
                        state         <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    s_apb_pready  <= 1'b0;
                    s_apb_pslverr <= 1'b0;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
